// File: rtl/wb_arbiter_n_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_n_if
// Bus bundle for the N-master to 1-slave Wishbone classic arbiter.
//
// The m_* group is the master-facing side: packed per-master requests in,
// broadcast read data plus per-master responses out. The s_* group is the
// single slave-facing side.
//
// Modports:
//   slave  - the arbiter: consumes master requests and slave responses,
//            drives slave controls and master responses.
//   master - the environment around the arbiter (masters plus the external
//            slave): drives requests and responses, observes the rest.
// -----------------------------------------------------------------------------
interface wb_arbiter_n_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = DATA_WIDTH / 8
);
  // Master side
  logic [NUM_MASTERS-1:0]            m_cyc_i;
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
  logic [DATA_WIDTH-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [NUM_MASTERS-1:0]            m_err_o;
  logic [NUM_MASTERS-1:0]            m_rty_o;

  // Slave side
  logic                              s_cyc_o;
  logic                              s_stb_o;
  logic                              s_we_o;
  logic [ADDR_WIDTH-1:0]             s_adr_o;
  logic [DATA_WIDTH-1:0]             s_dat_o;
  logic [SEL_WIDTH-1:0]              s_sel_o;
  logic [DATA_WIDTH-1:0]             s_dat_i;
  logic                              s_ack_i;
  logic                              s_err_i;
  logic                              s_rty_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );
endinterface

// File: rtl/wb_arbiter_n.sv
// -----------------------------------------------------------------------------
// wb_arbiter_n
// N-master to 1-slave Wishbone classic arbiter with fixed or round-robin
// priority, a locked grant for the length of each transfer, and a bus-timeout
// watchdog that terminates a stalled transfer with an error.
//
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset; forces every output to 0
//   bus        wb_arbiter_n_if.slave - master requests/responses and the
//              slave-side transfer
//   grant_o    one-hot owner (or same-cycle winner in IDLE); 0 when none
//   timeout_o  one-cycle pulse when the watchdog terminates a transfer
//
// Timing: in IDLE the winner is forwarded to the slave in the same cycle;
// the grant is registered on the following edge and held until the transfer
// ends (response, owner drops cyc, or watchdog). Every transfer returns
// through IDLE so arbitration happens once per transfer.
// -----------------------------------------------------------------------------
module wb_arbiter_n #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RR_MODE     = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wb_arbiter_n_if.slave          bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W     = $clog2(NUM_MASTERS);
  localparam int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_start;   // first index searched at the next arbitration
  logic [CNT_W-1:0] tmo_cnt;

  logic [IDX_W-1:0] search_start;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic             owned;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_vld;
  logic             cur_cyc;
  logic             resp;
  logic             fwd;
  logic             tmo_fire;

  // (base + off) mod NUM_MASTERS for off < NUM_MASTERS, without a divider.
  function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
    return IDX_W'(s);
  endfunction

  assign search_start = (RR_MODE != 0) ? rr_start : '0;

  // Scan from the far end back towards search_start so the requester closest
  // to the start position is written last and wins.
  always_comb begin : arbitrate
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (bus.m_cyc_i[wrap_idx(int'(search_start), i)]) begin
        win_vld = 1'b1;
        win_idx = wrap_idx(int'(search_start), i);
      end
    end
  end

  assign owned   = (state == OWNED);
  assign cur_idx = owned ? owner : win_idx;
  assign cur_vld = owned | win_vld;
  assign cur_cyc = cur_vld & bus.m_cyc_i[cur_idx];
  assign resp    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

  // Responses reach a master only while it holds a registered grant and still
  // asserts cyc; a response after the owner abandons the cycle is dropped.
  assign fwd = owned & cur_cyc;

  // A real response in the final cycle beats the watchdog.
  assign tmo_fire = (TIMEOUT != 0) && fwd && !resp && (tmo_cnt == TMO_LAST);

  always_comb begin : drive_outputs
    // NOTE: every output gets a default before any condition, so no path
    // leaves one unassigned and no latch is inferred.
    grant_o     = '0;
    timeout_o   = 1'b0;
    bus.m_dat_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    // Reset gates the outputs combinationally so they clear without a clock.
    if (!rst_i && cur_vld) begin
      grant_o[cur_idx] = 1'b1;
      bus.s_cyc_o      = cur_cyc & ~tmo_fire;
      bus.s_stb_o      = cur_cyc & bus.m_stb_i[cur_idx] & ~tmo_fire;
      bus.s_we_o       = bus.m_we_i[cur_idx];
      bus.s_adr_o      = bus.m_adr_i[cur_idx*ADDR_WIDTH +: ADDR_WIDTH];
      bus.s_dat_o      = bus.m_dat_i[cur_idx*DATA_WIDTH +: DATA_WIDTH];
      bus.s_sel_o      = bus.m_sel_i[cur_idx*SEL_WIDTH +: SEL_WIDTH];
      bus.m_dat_o      = bus.s_dat_i;
      if (fwd) begin
        bus.m_ack_o[cur_idx] = bus.s_ack_i;
        bus.m_err_o[cur_idx] = bus.s_err_i | tmo_fire;
        bus.m_rty_o[cur_idx] = bus.s_rty_i;
      end
      timeout_o = tmo_fire;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : fsm
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst_i) begin
      state    <= IDLE;
      owner    <= '0;
      rr_start <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state    <= OWNED;
            owner    <= win_idx;
            tmo_cnt  <= '0;
            rr_start <= (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
          end
        end
        OWNED: begin
          if (!cur_cyc || resp || tmo_fire) begin
            state   <= IDLE;
            tmo_cnt <= '0;
          end else if (bus.m_stb_i[owner] && (tmo_cnt != '1)) begin
            tmo_cnt <= tmo_cnt + 1'b1;   // saturating stall count
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter_n
// Drives a fixed-priority and a round-robin arbiter (3 masters, TIMEOUT=4)
// with identical request/response stimulus. Directed steps cover the main
// scenarios; a random phase follows. Both DUTs are compared every cycle
// against a transaction-level reference model kept in this file.
// -----------------------------------------------------------------------------
module tb_wb_arbiter_n;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #10 clk_i = ~clk_i;

  // Shared stimulus
  logic [N-1:0]    cyc, stb, we;
  logic [N*AW-1:0] adr;
  logic [N*DW-1:0] wdat;
  logic [N*SW-1:0] sel;
  logic [DW-1:0]   s_rdat;
  logic            s_ack, s_err, s_rty;

  wb_arbiter_n_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_fx ();
  wb_arbiter_n_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_rr ();

  assign bus_fx.m_cyc_i = cyc;   assign bus_rr.m_cyc_i = cyc;
  assign bus_fx.m_stb_i = stb;   assign bus_rr.m_stb_i = stb;
  assign bus_fx.m_we_i  = we;    assign bus_rr.m_we_i  = we;
  assign bus_fx.m_adr_i = adr;   assign bus_rr.m_adr_i = adr;
  assign bus_fx.m_dat_i = wdat;  assign bus_rr.m_dat_i = wdat;
  assign bus_fx.m_sel_i = sel;   assign bus_rr.m_sel_i = sel;
  assign bus_fx.s_dat_i = s_rdat; assign bus_rr.s_dat_i = s_rdat;
  assign bus_fx.s_ack_i = s_ack; assign bus_rr.s_ack_i = s_ack;
  assign bus_fx.s_err_i = s_err; assign bus_rr.s_err_i = s_err;
  assign bus_fx.s_rty_i = s_rty; assign bus_rr.s_rty_i = s_rty;

  logic [N-1:0] grant_fx, grant_rr;
  logic         timeout_fx, timeout_rr;

  wb_arbiter_n #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                 .RR_MODE(0), .TIMEOUT(TMO)) u_fx (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus_fx.slave),
    .grant_o   (grant_fx),
    .timeout_o (timeout_fx)
  );

  wb_arbiter_n #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                 .RR_MODE(1), .TIMEOUT(TMO)) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus_rr.slave),
    .grant_o   (grant_rr),
    .timeout_o (timeout_rr)
  );

  // Observable outputs of one DUT, bundled for comparison.
  typedef struct packed {
    logic [N-1:0]  grant;
    logic          s_cyc;
    logic          s_stb;
    logic          s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat;
    logic [SW-1:0] s_sel;
    logic [DW-1:0] m_dat;
    logic [N-1:0]  m_ack;
    logic [N-1:0]  m_err;
    logic [N-1:0]  m_rty;
    logic          tmo;
  } out_t;

  out_t obs_fx, obs_rr;
  assign obs_fx = {grant_fx, bus_fx.s_cyc_o, bus_fx.s_stb_o, bus_fx.s_we_o, bus_fx.s_adr_o,
                   bus_fx.s_dat_o, bus_fx.s_sel_o, bus_fx.m_dat_o, bus_fx.m_ack_o,
                   bus_fx.m_err_o, bus_fx.m_rty_o, timeout_fx};
  assign obs_rr = {grant_rr, bus_rr.s_cyc_o, bus_rr.s_stb_o, bus_rr.s_we_o, bus_rr.s_adr_o,
                   bus_rr.s_dat_o, bus_rr.s_sel_o, bus_rr.m_dat_o, bus_rr.m_ack_o,
                   bus_rr.m_err_o, bus_rr.m_rty_o, timeout_rr};

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model, index 0 = fixed priority, 1 = round-robin.
  // owner = -1 means nobody holds the bus; stall = stalled strobe cycles seen.
  // ---------------------------------------------------------------------------
  int mdl_owner [2];
  int mdl_stall [2];
  int mdl_last  [2];

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      mdl_owner[m] = -1;
      mdl_stall[m] = 0;
      mdl_last[m]  = N - 1;   // so master 0 is searched first
    end
  endfunction

  function automatic int pick_winner(input int m);
    int start;
    int found;
    start = (m == 1) ? (mdl_last[m] + 1) % N : 0;
    found = -1;
    for (int i = 0; i < N; i++) begin
      if (found < 0 && cyc[(start + i) % N]) found = (start + i) % N;
    end
    return found;
  endfunction

  function automatic int current(input int m);
    return (mdl_owner[m] >= 0) ? mdl_owner[m] : pick_winner(m);
  endfunction

  // The TMO-th stalled cycle of a live transfer ends it with an error.
  function automatic bit fires(input int m);
    int o;
    o = mdl_owner[m];
    if (o < 0) return 1'b0;
    return cyc[o] && !(s_ack || s_err || s_rty) && (mdl_stall[m] == TMO - 1);
  endfunction

  function automatic out_t expect_out(input int m);
    out_t e;
    int   cur;
    bit   f;
    e   = '0;
    cur = current(m);
    f   = fires(m);
    if (!rst_i && cur >= 0) begin
      e.grant[cur] = 1'b1;
      e.s_cyc      = cyc[cur] && !f;
      e.s_stb      = cyc[cur] && stb[cur] && !f;
      e.s_we       = we[cur];
      e.s_adr      = adr[cur*AW +: AW];
      e.s_dat      = wdat[cur*DW +: DW];
      e.s_sel      = sel[cur*SW +: SW];
      e.m_dat      = s_rdat;
      if (mdl_owner[m] >= 0 && cyc[cur]) begin
        e.m_ack[cur] = s_ack;
        e.m_err[cur] = s_err || f;
        e.m_rty[cur] = s_rty;
      end
      e.tmo = f;
    end
    return e;
  endfunction

  task automatic advance_model();
    for (int m = 0; m < 2; m++) begin
      if (rst_i) begin
        mdl_owner[m] = -1;
        mdl_stall[m] = 0;
        mdl_last[m]  = N - 1;
      end else if (mdl_owner[m] < 0) begin
        int w;
        w = pick_winner(m);
        if (w >= 0) begin
          mdl_owner[m] = w;
          mdl_stall[m] = 0;
          mdl_last[m]  = w;
        end
      end else if (!cyc[mdl_owner[m]] || s_ack || s_err || s_rty || fires(m)) begin
        mdl_owner[m] = -1;
      end else if (stb[mdl_owner[m]]) begin
        mdl_stall[m] = mdl_stall[m] + 1;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_dut(input string tag, input out_t o, input out_t e);
    check({tag, " grant"}, 64'(o.grant), 64'(e.grant));
    check({tag, " s_ctrl"}, 64'({o.s_cyc, o.s_stb, o.s_we}), 64'({e.s_cyc, e.s_stb, e.s_we}));
    check({tag, " s_adr"}, 64'(o.s_adr), 64'(e.s_adr));
    check({tag, " s_dat"}, 64'(o.s_dat), 64'(e.s_dat));
    check({tag, " s_sel"}, 64'(o.s_sel), 64'(e.s_sel));
    check({tag, " m_dat"}, 64'(o.m_dat), 64'(e.m_dat));
    check({tag, " m_resp"}, 64'({o.m_ack, o.m_err, o.m_rty}), 64'({e.m_ack, e.m_err, e.m_rty}));
    check({tag, " timeout"}, 64'(o.tmo), 64'(e.tmo));
  endtask

  // Settle combinational outputs and compare both DUTs with the model.
  task automatic sample(input string tag);
    #1;
    compare_dut({tag, "/fx"}, obs_fx, expect_out(0));
    compare_dut({tag, "/rr"}, obs_rr, expect_out(1));
  endtask

  task automatic clock_edge();
    @(posedge clk_i);
    advance_model();
    @(negedge clk_i);
  endtask

  task automatic set_req(input logic [N-1:0] mask);
    cyc = mask;
    stb = mask;
  endtask

  task automatic sync_reset();
    rst_i = 1'b1;
    model_reset();
    sample("reset");
    clock_edge();
    rst_i = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [N-1:0] exp_g;
    int r;

    // Reset with every input active: outputs must stay 0.
    set_req(3'b111);
    we     = 3'b111;
    adr    = {32'h0000_1200, 32'h0000_1100, 32'h0000_1000};
    wdat   = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    sel    = 12'hF3C;
    s_rdat = 32'h5A5A_A5A5;
    s_ack  = 1'b1;
    s_err  = 1'b0;
    s_rty  = 1'b0;
    model_reset();
    sample("rst_hold");
    check("rst_grant_fx", 64'(grant_fx), 64'(0));
    check("rst_scyc_rr", 64'(bus_rr.s_cyc_o), 64'(0));
    clock_edge();
    rst_i = 1'b0;
    s_ack = 1'b0;
    set_req(3'b000);

    // 1: fixed priority picks master 1 of 3'b110 in the same cycle.
    set_req(3'b110);
    sample("d1_idle");
    check("d1_grant", 64'(grant_fx), 64'(3'b010));
    check("d1_adr", 64'(bus_fx.s_adr_o), 64'(32'h0000_1100));
    clock_edge();
    sample("d1_wait");
    clock_edge();
    s_ack = 1'b1;
    sample("d1_ack");
    check("d1_ack_only_m1", 64'(bus_fx.m_ack_o), 64'(3'b010));
    clock_edge();
    s_ack = 1'b0;
    set_req(3'b000);
    sample("d1_back_idle");
    check("d1_released", 64'(grant_fx), 64'(0));
    clock_edge();

    // 2: all masters requesting, one-cycle slave -> RR rotates 0,1,2,...
    sync_reset();
    set_req(3'b111);
    for (int t = 0; t < 6; t++) begin
      s_ack = 1'b0;
      sample("d2_arb");
      exp_g = 3'b001 << (t % 3);
      check("d2_rr_grant", 64'(grant_rr), 64'(exp_g));
      check("d2_fx_grant", 64'(grant_fx), 64'(3'b001));
      clock_edge();
      s_ack = 1'b1;
      sample("d2_ack");
      clock_edge();
    end
    s_ack = 1'b0;
    set_req(3'b000);
    sample("d2_end");
    clock_edge();

    // 3: grant is locked against a higher-priority late request.
    set_req(3'b100);
    sample("d3_idle");
    clock_edge();
    set_req(3'b101);
    sample("d3_contend");
    check("d3_lock", 64'(grant_fx), 64'(3'b100));
    clock_edge();
    s_ack = 1'b1;
    sample("d3_ack");
    check("d3_lock_ack", 64'(grant_fx), 64'(3'b100));
    check("d3_ack_m2", 64'(bus_fx.m_ack_o), 64'(3'b100));
    clock_edge();
    s_ack = 1'b0;
    sample("d3_rearb");
    check("d3_m0_next", 64'(grant_fx), 64'(3'b001));
    clock_edge();
    s_ack = 1'b1;
    sample("d3_m0_ack");
    clock_edge();
    s_ack = 1'b0;
    set_req(3'b000);
    sample("d3_end");
    clock_edge();

    // 4: silent slave -> error and timeout pulse on the 4th owned cycle.
    set_req(3'b010);
    sample("d4_idle");
    clock_edge();
    for (int c = 1; c <= TMO; c++) begin
      sample("d4_stall");
      check("d4_no_ack", 64'(bus_fx.m_ack_o), 64'(0));
      if (c < TMO) begin
        check("d4_no_tmo", 64'(timeout_fx), 64'(0));
        check("d4_scyc_on", 64'(bus_fx.s_cyc_o), 64'(1));
      end else begin
        check("d4_err", 64'(bus_fx.m_err_o), 64'(3'b010));
        check("d4_tmo", 64'(timeout_fx), 64'(1));
        check("d4_scyc_off", 64'(bus_fx.s_cyc_o), 64'(0));
      end
      clock_edge();
    end
    set_req(3'b000);
    sample("d4_after");
    check("d4_idle_after", 64'(grant_fx), 64'(0));
    check("d4_no_ack_after", 64'(bus_fx.m_ack_o), 64'(0));
    clock_edge();

    // 5: owner abandons; late ack dropped; waiting master granted next.
    set_req(3'b011);
    sample("d5_idle");
    check("d5_grant_m0", 64'(grant_fx), 64'(3'b001));
    clock_edge();
    sample("d5_wait");
    clock_edge();
    set_req(3'b010);
    s_ack = 1'b1;
    sample("d5_drop");
    check("d5_scyc_drop", 64'(bus_fx.s_cyc_o), 64'(0));
    check("d5_late_ack", 64'(bus_fx.m_ack_o), 64'(0));
    clock_edge();
    s_ack = 1'b0;
    sample("d5_next");
    check("d5_grant_m1", 64'(grant_fx), 64'(3'b010));
    clock_edge();
    s_ack = 1'b1;
    sample("d5_m1_ack");
    clock_edge();
    s_ack = 1'b0;
    set_req(3'b000);
    sample("d5_end");
    clock_edge();

    // 6: asynchronous reset mid-transfer, then same-cycle grant after release.
    set_req(3'b100);
    sample("d6_idle");
    clock_edge();
    sample("d6_owned");
    rst_i = 1'b1;
    model_reset();
    sample("d6_in_rst");
    check("d6_rst_grant_rr", 64'(grant_rr), 64'(0));
    check("d6_rst_scyc_fx", 64'(bus_fx.s_cyc_o), 64'(0));
    rst_i = 1'b0;
    set_req(3'b001);
    sample("d6_release");
    check("d6_grant_m0", 64'(grant_rr), 64'(3'b001));
    set_req(3'b111);
    sample("d6_rr_start");
    check("d6_rr_ptr0", 64'(grant_rr), 64'(3'b001));
    clock_edge();
    s_ack = 1'b1;
    sample("d6_ack");
    clock_edge();
    s_ack = 1'b0;
    set_req(3'b000);
    sample("d6_end");
    clock_edge();

    // Random phase: sticky requests, stb tracks cyc, mixed slave responses.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) begin
        if (cyc[i]) cyc[i] = ($urandom_range(99) < 85);
        else        cyc[i] = ($urandom_range(99) < 40);
      end
      stb    = cyc;
      we     = 3'($urandom);
      adr    = {$urandom, $urandom, $urandom};
      wdat   = {$urandom, $urandom, $urandom};
      sel    = 12'($urandom);
      s_rdat = $urandom;
      r      = int'($urandom_range(99));
      s_ack  = (r < 25);
      s_err  = (r >= 25 && r < 30);
      s_rty  = (r >= 30 && r < 35);
      sample("rand");
      clock_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_n.md
Name: wb_arbiter_n

Overview:
- Parametrised N-master to 1-slave Wishbone classic arbiter. Successor to the two-port IF/MEM bus mux.
- Sits between the core's masters (IF, MEM, future DMA/debug) and the external bus.
- Adds a channel count parameter, selectable fixed or round-robin priority, a bus-timeout watchdog with error return, and grant/status outputs.

Parameters:
- NUM_MASTERS, 2, number of master ports (2..8); index 0 is highest fixed priority.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; SEL_WIDTH = DATA_WIDTH/8.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, 255, maximum cycles a granted transfer may wait for ack/err/rty; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- m_cyc_i  in  NUM_MASTERS  per-master cyc
- m_stb_i  in  NUM_MASTERS  per-master stb
- m_we_i  in  NUM_MASTERS  per-master we
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master k occupies slice k
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
- m_sel_i  in  NUM_MASTERS*SEL_WIDTH  packed byte selects
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  per-master ack
- m_err_o  out  NUM_MASTERS  per-master err
- m_rty_o  out  NUM_MASTERS  per-master rty
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls
- s_adr_o  out  ADDR_WIDTH  slave address
- s_dat_o  out  DATA_WIDTH  slave write data
- s_sel_o  out  SEL_WIDTH  slave byte selects
- s_dat_i  in  DATA_WIDTH  slave read data
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave responses
- grant_o  out  NUM_MASTERS  one-hot current owner; all-zero when none
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset is asynchronous. While rst_i is high:
  - state = IDLE, owner = none, timeout counter = 0.
  - Round-robin pointer reset so master 0 is searched first.
  - All outputs are forced to 0, regardless of inputs.
- State machine has two states: IDLE and OWNED.
- IDLE:
  - The arbitration winner is computed combinationally from m_cyc_i.
  - The winner is passed through in the same cycle (zero added latency) and drives grant_o.
  - On the next edge: state = OWNED, owner = winner, counter = 0.
  - If no m_cyc_i is set: s_cyc_o/s_stb_o = 0 and other slave outputs = 0.
- Fixed priority (RR_MODE=0): the lowest set index of m_cyc_i wins.
- Round-robin (RR_MODE=1):
  - The search starts at (last_owner+1) mod NUM_MASTERS.
  - last_owner updates when a grant is registered.
- OWNED:
  - The owner's signals are muxed to the slave; slave responses route only to m_*_o[owner]. Non-owners see ack/err/rty = 0.
  - m_dat_o = s_dat_i whenever an owner or winner exists, else 0.
  - Return to IDLE on the edge after the first of:
    - m_cyc_i[owner] low: the owner abandons the cycle, and s_cyc_o drops in that same cycle.
    - s_ack_i, s_err_i or s_rty_i high.
  - The grant is locked: the owner cannot be preempted by higher-priority requests.
- Back-to-back transfers:
  - After each terminated transfer the arbiter passes through IDLE, so re-arbitration happens every transfer.
  - A master holding cyc across transfers may win again (fixed mode) or is rotated out (RR mode) when other masters are requesting.
- Watchdog (TIMEOUT>0):
  - The counter increments each OWNED cycle with s_stb_o=1 and no ack/err/rty.
  - When the counter equals TIMEOUT-1 with no response:
    - m_err_o[owner] = 1 and timeout_o = 1 for that cycle.
    - s_cyc_o/s_stb_o = 0 for that cycle.
    - Next state is IDLE.
  - The counter width is clog2(TIMEOUT+1). The counter saturates and never wraps.
- Simultaneous events:
  - A response in the same cycle as the timeout: the response wins; no err, no timeout_o.
  - A response while the owner has dropped cyc is not forwarded.
- Reset mid-transfer: outputs go to 0 immediately (asynchronously); the slave-side transfer is abandoned.

Test Plan:
- Fixed mode, NUM_MASTERS=3: m_cyc_i=3'b110 in IDLE -> grant_o=3'b010 in the same cycle, s_adr_o = master1 address; ack after 2 cycles -> only m_ack_o[1] set; IDLE on the next edge.
- Round-robin mode, all 3 masters requesting continuously, slave acks after 1 cycle -> grant sequence 0,1,2,0,1,2.
- Lock: master 2 owns the bus, master 0 raises cyc mid-transfer -> grant stays 3'b100 until ack; master 0 is granted on the next IDLE cycle.
- TIMEOUT=4, slave never acks -> exactly 4 OWNED cycles, err on the 4th with timeout_o=1 and s_cyc_o=0; IDLE next; m_ack_o stays 0 throughout.
- The owner drops m_cyc_i after 1 cycle with no ack -> s_cyc_o=0 in the same cycle; a pending second master is granted the following cycle; a late s_ack_i is not routed.
- Assert rst_i asynchronously mid-OWNED -> all outputs 0 before the next clock edge; after release, an m_cyc_i=3'b001 request is granted in the same cycle and the RR pointer starts at 0.
